// File: rtl/vxe_regio_pkg.sv
// Shared register indices, identification constant and access-rule helpers
// for the VxE host register file.
package vxe_regio_pkg;

    localparam int REG_IDX_W = 10;
    localparam logic [31:0] VXE_ID = 32'h5658_0100;

    localparam logic [REG_IDX_W-1:0] REG_ID                  = 10'd0;
    localparam logic [REG_IDX_W-1:0] REG_CTRL                = 10'd1;
    localparam logic [REG_IDX_W-1:0] REG_STATUS              = 10'd2;
    localparam logic [REG_IDX_W-1:0] REG_INTR_ACT            = 10'd3;
    localparam logic [REG_IDX_W-1:0] REG_INTR_MSK            = 10'd4;
    localparam logic [REG_IDX_W-1:0] REG_INTR_RAW            = 10'd5;
    localparam logic [REG_IDX_W-1:0] REG_PGM_ADDR_LO         = 10'd6;
    localparam logic [REG_IDX_W-1:0] REG_PGM_ADDR_HI         = 10'd7;
    localparam logic [REG_IDX_W-1:0] REG_START               = 10'd8;
    localparam logic [REG_IDX_W-1:0] REG_FAULT_INSTR_ADDR_LO = 10'd9;
    localparam logic [REG_IDX_W-1:0] REG_FAULT_INSTR_ADDR_HI = 10'd10;
    localparam logic [REG_IDX_W-1:0] REG_FAULT_INSTR_LO      = 10'd11;
    localparam logic [REG_IDX_W-1:0] REG_FAULT_INSTR_HI      = 10'd12;
    localparam logic [REG_IDX_W-1:0] REG_FAULT_VPU_MASK0     = 10'd13;

    // Decoded effect of a single write request.
    typedef struct packed {
        logic err;
        logic ctrl;
        logic msk;
        logic pgm_lo;
        logic pgm_hi;
        logic start;
        logic ack;
    } wr_dec_t;

endpackage

// File: rtl/vxe_regio.sv
// Host-visible register file of the VxE vector engine: registered read/write
// handshake, control/mask/program-address state, CU start and INTU acknowledge.
module vxe_regio
    import vxe_regio_pkg::*;
(
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [REG_IDX_W-1:0] i_wreg_idx,
    input  logic [31:0]          i_wdata,
    input  logic                 i_wenable,
    output logic                 o_waccept,
    output logic                 o_werror,
    input  logic [REG_IDX_W-1:0] i_rreg_idx,
    output logic [31:0]          o_rdata,
    input  logic                 i_renable,
    output logic                 o_raccept,
    output logic                 o_rerror,
    input  logic                 i_cu_busy,
    input  logic [36:0]          i_cu_last_instr_addr,
    input  logic [63:0]          i_cu_last_instr_data,
    input  logic [1:0]           i_vpu_fault,
    output logic [36:0]          o_cu_pgm_addr,
    output logic                 o_cu_start,
    input  logic [3:0]           i_intu_raw,
    input  logic [3:0]           i_intu_act,
    output logic [3:0]           o_intu_msk,
    output logic                 o_intu_ack_vld,
    output logic [3:0]           o_intu_ack,
    output logic                 o_cu_mas_sel
);

    logic        mas_sel_q;
    logic [3:0]  msk_q;
    logic [28:0] pgm_lo_q;   // byte address bits [31:3]
    logic [7:0]  pgm_hi_q;   // byte address bits [39:32]

    wr_dec_t     wr_dec;
    logic        rd_err;
    logic [31:0] rd_val;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_dec     = '0;
        wr_dec.err = 1'b1;
        case (i_wreg_idx)
            REG_CTRL:        begin wr_dec.err = 1'b0; wr_dec.ctrl   = 1'b1; end
            REG_INTR_ACT:    begin wr_dec.err = 1'b0; wr_dec.ack    = 1'b1; end
            REG_INTR_MSK:    begin wr_dec.err = 1'b0; wr_dec.msk    = 1'b1; end
            REG_PGM_ADDR_LO: begin wr_dec.err = 1'b0; wr_dec.pgm_lo = 1'b1; end
            REG_PGM_ADDR_HI: begin wr_dec.err = 1'b0; wr_dec.pgm_hi = 1'b1; end
            REG_START: begin
                if (!i_cu_busy) begin
                    wr_dec.err   = 1'b0;
                    wr_dec.start = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reads see register state as it was before a concurrent write lands.
    always_comb begin
        rd_err = 1'b0;
        rd_val = '0;
        case (i_rreg_idx)
            REG_ID:                  rd_val = VXE_ID;
            REG_CTRL:                rd_val = {31'b0, mas_sel_q};
            REG_STATUS:              rd_val = {31'b0, i_cu_busy};
            REG_INTR_ACT:            rd_val = {28'b0, i_intu_act};
            REG_INTR_MSK:            rd_val = {28'b0, msk_q};
            REG_INTR_RAW:            rd_val = {28'b0, i_intu_raw};
            REG_PGM_ADDR_LO:         rd_val = {pgm_lo_q, 3'b0};
            REG_PGM_ADDR_HI:         rd_val = {24'b0, pgm_hi_q};
            REG_FAULT_INSTR_ADDR_LO: rd_val = {i_cu_last_instr_addr[28:0], 3'b0};
            REG_FAULT_INSTR_ADDR_HI: rd_val = {24'b0, i_cu_last_instr_addr[36:29]};
            REG_FAULT_INSTR_LO:      rd_val = i_cu_last_instr_data[31:0];
            REG_FAULT_INSTR_HI:      rd_val = i_cu_last_instr_data[63:32];
            REG_FAULT_VPU_MASK0:     rd_val = {30'b0, i_vpu_fault};
            default:                 rd_err = 1'b1;  // REG_START is write-only
        endcase
    end

    // NOTE: state uses non-blocking assignments and a synchronous reset that
    // is checked first, so every flop clears on the edge nrst is seen low.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            mas_sel_q      <= 1'b0;
            msk_q          <= '0;
            pgm_lo_q       <= '0;
            pgm_hi_q       <= '0;
            o_waccept      <= 1'b0;
            o_werror       <= 1'b0;
            o_cu_start     <= 1'b0;
            o_intu_ack_vld <= 1'b0;
            o_intu_ack     <= '0;
            o_raccept      <= 1'b0;
            o_rerror       <= 1'b0;
            o_rdata        <= '0;
        end else begin
            o_waccept      <= i_wenable;
            o_werror       <= i_wenable & wr_dec.err;
            o_cu_start     <= i_wenable & wr_dec.start;
            o_intu_ack_vld <= i_wenable & wr_dec.ack;
            o_intu_ack     <= (i_wenable & wr_dec.ack) ? i_wdata[3:0] : 4'b0;

            if (i_wenable) begin
                if (wr_dec.ctrl)   mas_sel_q <= i_wdata[0];
                if (wr_dec.msk)    msk_q     <= i_wdata[3:0];
                if (wr_dec.pgm_lo) pgm_lo_q  <= i_wdata[31:3];
                if (wr_dec.pgm_hi) pgm_hi_q  <= i_wdata[7:0];
            end

            o_raccept <= i_renable;
            o_rerror  <= i_renable & rd_err;
            o_rdata   <= (i_renable & ~rd_err) ? rd_val : 32'b0;
        end
    end

    assign o_cu_mas_sel  = mas_sel_q;
    assign o_intu_msk    = msk_q;
    assign o_cu_pgm_addr = {pgm_hi_q, pgm_lo_q};

endmodule

// File: tb/tb_vxe_regio.sv
// Self-checking bench for vxe_regio: directed register-map walk with literal
// expectations, then randomized traffic compared every cycle against a model.
module tb_vxe_regio;

    logic        clk;
    logic        nrst;
    logic [9:0]  i_wreg_idx;
    logic [31:0] i_wdata;
    logic        i_wenable;
    logic        o_waccept;
    logic        o_werror;
    logic [9:0]  i_rreg_idx;
    logic [31:0] o_rdata;
    logic        i_renable;
    logic        o_raccept;
    logic        o_rerror;
    logic        i_cu_busy;
    logic [36:0] i_cu_last_instr_addr;
    logic [63:0] i_cu_last_instr_data;
    logic [1:0]  i_vpu_fault;
    logic [36:0] o_cu_pgm_addr;
    logic        o_cu_start;
    logic [3:0]  i_intu_raw;
    logic [3:0]  i_intu_act;
    logic [3:0]  o_intu_msk;
    logic        o_intu_ack_vld;
    logic [3:0]  o_intu_ack;
    logic        o_cu_mas_sel;

    vxe_regio dut (
        .clk                  (clk),
        .nrst                 (nrst),
        .i_wreg_idx           (i_wreg_idx),
        .i_wdata              (i_wdata),
        .i_wenable            (i_wenable),
        .o_waccept            (o_waccept),
        .o_werror             (o_werror),
        .i_rreg_idx           (i_rreg_idx),
        .o_rdata              (o_rdata),
        .i_renable            (i_renable),
        .o_raccept            (o_raccept),
        .o_rerror             (o_rerror),
        .i_cu_busy            (i_cu_busy),
        .i_cu_last_instr_addr (i_cu_last_instr_addr),
        .i_cu_last_instr_data (i_cu_last_instr_data),
        .i_vpu_fault          (i_vpu_fault),
        .o_cu_pgm_addr        (o_cu_pgm_addr),
        .o_cu_start           (o_cu_start),
        .i_intu_raw           (i_intu_raw),
        .i_intu_act           (i_intu_act),
        .o_intu_msk           (o_intu_msk),
        .o_intu_ack_vld       (o_intu_ack_vld),
        .o_intu_ack           (o_intu_ack),
        .o_cu_mas_sel         (o_cu_mas_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: architectural state as a 40-bit byte address plus flags.
    logic        m_mas_sel;
    logic [3:0]  m_msk;
    logic [39:0] m_pgm_byte;
    logic        model_valid = 1'b0;

    logic        e_wacc, e_werr, e_start, e_ackv;
    logic [3:0]  e_ack;
    logic        e_racc, e_rerr;
    logic [31:0] e_rdata;

    function automatic logic readable(input logic [9:0] idx);
        return (idx <= 10'd13) && (idx != 10'd8);
    endfunction

    function automatic logic writable(input logic [9:0] idx, input logic busy);
        return (idx == 10'd1) || (idx == 10'd3) || (idx == 10'd4) ||
               (idx == 10'd6) || (idx == 10'd7) || ((idx == 10'd8) && !busy);
    endfunction

    function automatic logic [31:0] model_read(input logic [9:0] idx);
        logic [31:0] v;
        v = 32'h0;
        case (idx)
            10'd0:  v = 32'h5658_0100;
            10'd1:  v = 32'(m_mas_sel);
            10'd2:  v = 32'(i_cu_busy);
            10'd3:  v = 32'(i_intu_act);
            10'd4:  v = 32'(m_msk);
            10'd5:  v = 32'(i_intu_raw);
            10'd6:  v = m_pgm_byte[31:0];
            10'd7:  v = 32'(m_pgm_byte[39:32]);
            10'd9:  v = 32'(i_cu_last_instr_addr) * 32'd8;
            10'd10: v = 32'(i_cu_last_instr_addr >> 29);
            10'd11: v = i_cu_last_instr_data[31:0];
            10'd12: v = i_cu_last_instr_data[63:32];
            10'd13: v = 32'(i_vpu_fault);
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        model_valid <= 1'b1;
        if (!nrst) begin
            m_mas_sel  <= 1'b0;
            m_msk      <= 4'h0;
            m_pgm_byte <= 40'h0;
            e_wacc     <= 1'b0;
            e_werr     <= 1'b0;
            e_start    <= 1'b0;
            e_ackv     <= 1'b0;
            e_ack      <= 4'h0;
            e_racc     <= 1'b0;
            e_rerr     <= 1'b0;
            e_rdata    <= 32'h0;
        end else begin
            e_racc  <= i_renable;
            e_rerr  <= i_renable && !readable(i_rreg_idx);
            e_rdata <= (i_renable && readable(i_rreg_idx)) ? model_read(i_rreg_idx) : 32'h0;
            e_wacc  <= i_wenable;
            e_werr  <= i_wenable && !writable(i_wreg_idx, i_cu_busy);
            e_start <= i_wenable && (i_wreg_idx == 10'd8) && !i_cu_busy;
            e_ackv  <= i_wenable && (i_wreg_idx == 10'd3);
            e_ack   <= (i_wenable && (i_wreg_idx == 10'd3)) ? i_wdata[3:0] : 4'h0;
            if (i_wenable) begin
                case (i_wreg_idx)
                    10'd1: m_mas_sel <= i_wdata[0];
                    10'd4: m_msk <= i_wdata[3:0];
                    10'd6: m_pgm_byte[31:0] <= i_wdata & 32'hffff_fff8;
                    10'd7: m_pgm_byte[39:32] <= i_wdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("waccept",  64'(o_waccept),      64'(e_wacc));
            check("werror",   64'(o_werror),       64'(e_werr));
            check("cu_start", 64'(o_cu_start),     64'(e_start));
            check("ack_vld",  64'(o_intu_ack_vld), 64'(e_ackv));
            check("ack",      64'(o_intu_ack),     64'(e_ack));
            check("raccept",  64'(o_raccept),      64'(e_racc));
            check("rerror",   64'(o_rerror),       64'(e_rerr));
            check("rdata",    64'(o_rdata),        64'(e_rdata));
            check("mas_sel",  64'(o_cu_mas_sel),   64'(m_mas_sel));
            check("intu_msk", 64'(o_intu_msk),     64'(m_msk));
            check("pgm_addr", 64'(o_cu_pgm_addr),  64'(m_pgm_byte[39:3]));
        end
    end

    task automatic do_write(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        i_wreg_idx = idx;
        i_wdata    = data;
        i_wenable  = 1'b1;
        @(negedge clk);
        i_wenable  = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] idx);
        @(negedge clk);
        i_rreg_idx = idx;
        i_renable  = 1'b1;
        @(negedge clk);
        i_renable  = 1'b0;
    endtask

    logic [31:0] lit_rd [14];

    initial begin
        nrst = 1'b0;
        i_wreg_idx = '0; i_wdata = '0; i_wenable = 1'b0;
        i_rreg_idx = '0; i_renable = 1'b0;
        i_cu_busy = 1'b0; i_cu_last_instr_addr = '0; i_cu_last_instr_data = '0;
        i_vpu_fault = '0; i_intu_raw = '0; i_intu_act = '0;
        repeat (3) @(negedge clk);
        check("reset waccept",  64'(o_waccept),     64'h0);
        check("reset rdata",    64'(o_rdata),       64'h0);
        check("reset pgm_addr", 64'(o_cu_pgm_addr), 64'h0);
        check("reset msk",      64'(o_intu_msk),    64'h0);
        nrst = 1'b1;

        i_cu_busy = 1'b1;
        i_cu_last_instr_addr = 37'h1f_0102_0304;
        i_cu_last_instr_data = 64'hbeef_deaf_cafe_feed;
        i_vpu_fault = 2'b11; i_intu_raw = 4'hf; i_intu_act = 4'h7;
        lit_rd = '{32'h5658_0100, 32'h0, 32'h1, 32'h7, 32'h0, 32'hf, 32'h0, 32'h0,
                   32'h0, 32'h0810_1820, 32'hf8, 32'hcafe_feed, 32'hbeef_deaf, 32'h3};
        for (int i = 0; i < 14; i++) begin
            do_read(10'(i));
            check($sformatf("lit rd%0d rdata", i), 64'(o_rdata), 64'(lit_rd[i]));
            check($sformatf("lit rd%0d rerror", i), 64'(o_rerror), (i == 8) ? 64'h1 : 64'h0);
        end

        do_write(10'd8, 32'h1);
        check("lit start busy werror", 64'(o_werror), 64'h1);
        check("lit start busy pulse", 64'(o_cu_start), 64'h0);
        i_cu_busy = 1'b0;
        do_write(10'd8, 32'h0);
        check("lit start pulse", 64'({o_cu_start, o_waccept, o_werror}), 64'b110);
        @(negedge clk);
        check("lit start one cycle", 64'(o_cu_start), 64'h0);

        do_write(10'd1, 32'h1);
        check("lit mas_sel", 64'(o_cu_mas_sel), 64'h1);
        do_write(10'd4, 32'hdddd_ddde);
        check("lit msk", 64'(o_intu_msk), 64'he);
        do_read(10'd4);
        check("lit msk read", 64'(o_rdata), 64'h0000_000e);
        do_write(10'd3, 32'hdddd_dddc);
        check("lit ack", 64'({o_intu_ack_vld, o_intu_ack}), 64'h1c);
        @(negedge clk);
        check("lit ack one cycle", 64'(o_intu_ack_vld), 64'h0);

        do_write(10'd6, 32'hcafe_beef);
        do_write(10'd7, 32'hdddd_abba);
        check("lit pgm_addr", 64'(o_cu_pgm_addr), 64'({8'hba, 29'h195f_d7dd}));
        do_read(10'd6);
        check("lit pgm lo read", 64'(o_rdata), 64'hcafe_bee8);
        do_read(10'd7);
        check("lit pgm hi read", 64'(o_rdata), 64'h0000_00ba);

        do_write(10'd0, 32'hffff_ffff);
        check("lit ro werror", 64'(o_werror), 64'h1);
        do_write(10'd100, 32'hffff_ffff);
        check("lit unmapped werror", 64'(o_werror), 64'h1);
        check("lit state kept", 64'({o_cu_mas_sel, o_intu_msk}), 64'h1e);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            nrst       = !(c >= 1500 && c < 1502);
            i_wenable  = ($urandom_range(0, 2) != 0);
            i_renable  = ($urandom_range(0, 2) != 0);
            i_wreg_idx = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            i_rreg_idx = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            i_wdata    = $urandom;
            i_cu_busy  = 1'($urandom);
            i_cu_last_instr_addr = {5'($urandom), 32'($urandom)};
            i_cu_last_instr_data = {32'($urandom), 32'($urandom)};
            i_vpu_fault = 2'($urandom);
            i_intu_raw  = 4'($urandom);
            i_intu_act  = 4'($urandom);
        end
        @(negedge clk);
        i_wenable = 1'b0;
        i_renable = 1'b0;
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
